// File: rtl/jtframe_sram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sram_arb_if
// Description : Two requester ports plus the external async SRAM pin group
//               shared by the SRAM arbiter and its surroundings.
// Revision    : 1.0  initial release
// ============================================================================
interface jtframe_sram_arb_if #(
  parameter int AW = 21
);
  // port 0 (high priority, video read-out)
  logic          p0_cs;
  logic [AW-1:0] p0_addr;
  logic          p0_we;
  logic [15:0]   p0_din;
  logic [1:0]    p0_dsn;
  logic [15:0]   p0_dout;
  logic          p0_ok;
  // port 1 (low priority, general access)
  logic          p1_cs;
  logic [AW-1:0] p1_addr;
  logic          p1_we;
  logic [15:0]   p1_din;
  logic [1:0]    p1_dsn;
  logic [15:0]   p1_dout;
  logic          p1_ok;
  // SRAM pin side
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dout;
  logic [15:0]   sram_din;
  logic          sram_doe;
  logic          sram_we_n;
  logic          sram_oe_n;
  logic          sram_ub_n;
  logic          sram_lb_n;
  logic          busy;

  modport slave (
    input  p0_cs, p0_addr, p0_we, p0_din, p0_dsn,
    input  p1_cs, p1_addr, p1_we, p1_din, p1_dsn,
    input  sram_din,
    output p0_dout, p0_ok, p1_dout, p1_ok,
    output sram_addr, sram_dout, sram_doe, sram_we_n, sram_oe_n,
    output sram_ub_n, sram_lb_n, busy
  );

  modport master (
    output p0_cs, p0_addr, p0_we, p0_din, p0_dsn,
    output p1_cs, p1_addr, p1_we, p1_din, p1_dsn,
    output sram_din,
    input  p0_dout, p0_ok, p1_dout, p1_ok,
    input  sram_addr, sram_dout, sram_doe, sram_we_n, sram_oe_n,
    input  sram_ub_n, sram_lb_n, busy
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_sram_arb.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_sram_arb
// Description : Two-port arbiter for a 16-bit asynchronous SRAM. Port 0 has
//               priority, port 1 is protected from starvation by a bounded
//               grant counter. Strobes are sequenced SETUP/ACCESS/HOLD with
//               WAIT strobe-active cycles; every output is registered.
// Revision    : 1.0  initial release
// ============================================================================
module jtframe_sram_arb #(
  parameter int AW     = 21,
  parameter int WAIT   = 2,
  parameter int STARVE = 8
) (
  input  logic              clk,
  input  logic              rst,
  jtframe_sram_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] WAIT_LAST  = 4'(WAIT - 1);
  localparam logic [7:0] STARVE_MAX = 8'(STARVE);

  logic [1:0]    state_q, state_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [7:0]    starve_q, starve_d;
  logic          grant_q, grant_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   din_q, din_d;
  logic [1:0]    dsn_q, dsn_d;

  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]   sram_dout_q, sram_dout_d;
  logic          sram_doe_q, sram_doe_d;
  logic          sram_we_n_q, sram_we_n_d;
  logic          sram_oe_n_q, sram_oe_n_d;
  logic          sram_ub_n_q, sram_ub_n_d;
  logic          sram_lb_n_q, sram_lb_n_d;
  logic [15:0]   p0_dout_q, p0_dout_d;
  logic [15:0]   p1_dout_q, p1_dout_d;
  logic          p0_ok_q, p0_ok_d;
  logic          p1_ok_q, p1_ok_d;
  logic          busy_q, busy_d;

  // State register plus the request latched at grant time
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= 4'd0;
      starve_q <= 8'd0;
      grant_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= 16'd0;
      dsn_q    <= 2'b11;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      starve_q <= starve_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dsn_q    <= dsn_d;
    end
  end

  // Next state: arbitration in IDLE, wait-state counting in ACCESS
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    starve_d = starve_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dsn_d    = dsn_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.p1_cs) starve_d = 8'd0;
        if (bus.p0_cs || bus.p1_cs) begin
          state_d = ST_SETUP;
          if (bus.p0_cs && bus.p1_cs) begin
            // port 1 wins once port 0 has had STARVE grants in a row
            if (starve_q < STARVE_MAX) begin
              grant_d  = 1'b0;
              starve_d = starve_q + 8'd1;
            end else begin
              grant_d  = 1'b1;
              starve_d = 8'd0;
            end
          end else begin
            grant_d = bus.p1_cs;
            if (bus.p1_cs) starve_d = 8'd0;
          end
          if (grant_d) begin
            we_d   = bus.p1_we;
            addr_d = bus.p1_addr;
            din_d  = bus.p1_din;
            dsn_d  = bus.p1_dsn;
          end else begin
            we_d   = bus.p0_we;
            addr_d = bus.p0_addr;
            din_d  = bus.p0_din;
            dsn_d  = bus.p0_dsn;
          end
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wcnt_d  = WAIT_LAST;
      end
      ST_ACCESS: begin
        if (wcnt_q == 4'd0) state_d = ST_HOLD;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every pin leaves a flop
  always_comb begin
    sram_addr_d = '0;
    sram_dout_d = 16'd0;
    sram_doe_d  = 1'b0;
    sram_we_n_d = 1'b1;
    sram_oe_n_d = 1'b1;
    sram_ub_n_d = 1'b1;
    sram_lb_n_d = 1'b1;
    p0_ok_d     = 1'b0;
    p1_ok_d     = 1'b0;
    p0_dout_d   = p0_dout_q;
    p1_dout_d   = p1_dout_q;
    busy_d      = (state_d != ST_IDLE);
    if (state_d != ST_IDLE) begin
      sram_addr_d = addr_d;
      if (we_d) begin
        // write data stays on the bus through HOLD for hold time
        sram_doe_d  = 1'b1;
        sram_dout_d = din_d;
        sram_ub_n_d = dsn_d[1];
        sram_lb_n_d = dsn_d[0];
        sram_we_n_d = (state_d != ST_ACCESS);
      end else begin
        sram_oe_n_d = (state_d == ST_HOLD);
        sram_ub_n_d = (state_d == ST_HOLD);
        sram_lb_n_d = (state_d == ST_HOLD);
      end
    end
    if (state_q == ST_ACCESS && state_d == ST_HOLD) begin
      p0_ok_d = !grant_q;
      p1_ok_d = grant_q;
      if (!we_q) begin
        if (grant_q) p1_dout_d = bus.sram_din;
        else         p0_dout_d = bus.sram_din;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_q <= '0;
      sram_dout_q <= 16'd0;
      sram_doe_q  <= 1'b0;
      sram_we_n_q <= 1'b1;
      sram_oe_n_q <= 1'b1;
      sram_ub_n_q <= 1'b1;
      sram_lb_n_q <= 1'b1;
      p0_dout_q   <= 16'd0;
      p1_dout_q   <= 16'd0;
      p0_ok_q     <= 1'b0;
      p1_ok_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_doe_q  <= sram_doe_d;
      sram_we_n_q <= sram_we_n_d;
      sram_oe_n_q <= sram_oe_n_d;
      sram_ub_n_q <= sram_ub_n_d;
      sram_lb_n_q <= sram_lb_n_d;
      p0_dout_q   <= p0_dout_d;
      p1_dout_q   <= p1_dout_d;
      p0_ok_q     <= p0_ok_d;
      p1_ok_q     <= p1_ok_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.sram_addr = sram_addr_q;
  assign bus.sram_dout = sram_dout_q;
  assign bus.sram_doe  = sram_doe_q;
  assign bus.sram_we_n = sram_we_n_q;
  assign bus.sram_oe_n = sram_oe_n_q;
  assign bus.sram_ub_n = sram_ub_n_q;
  assign bus.sram_lb_n = sram_lb_n_q;
  assign bus.p0_dout   = p0_dout_q;
  assign bus.p1_dout   = p1_dout_q;
  assign bus.p0_ok     = p0_ok_q;
  assign bus.p1_ok     = p1_ok_q;
  assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtframe_sram_arb
// Description : Self-checking bench for jtframe_sram_arb with an SRAM model
//               and a transaction-level memory reference.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jtframe_sram_arb;

  localparam int AW = 21;
  localparam int WA = 2;
  localparam int SA = 2;
  localparam int WB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtframe_sram_arb_if #(.AW(AW)) bus_a ();
  jtframe_sram_arb_if #(.AW(AW)) bus_b ();

  jtframe_sram_arb #(.AW(AW), .WAIT(WA), .STARVE(SA)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  jtframe_sram_arb #(.AW(AW), .WAIT(WB), .STARVE(8)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- SRAM pin model (what the DUT actually wrote) ----------
  logic [15:0] sram [logic [AW-1:0]];
  // ---------------- reference memory (what should have been written) -----
  logic [15:0] ref_mem [logic [AW-1:0]];

  function automatic logic [15:0] pat(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction
  function automatic logic [15:0] sram_rd(input logic [AW-1:0] a);
    return sram.exists(a) ? sram[a] : pat(a);
  endfunction
  function automatic logic [15:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pat(a);
  endfunction
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] dsn);
    return {dsn[1] ? old[15:8] : d[15:8], dsn[0] ? old[7:0] : d[7:0]};
  endfunction

  always @(posedge clk) begin
    if (!bus_a.sram_we_n && bus_a.sram_doe)
      sram[bus_a.sram_addr] = merge(sram_rd(bus_a.sram_addr), bus_a.sram_dout,
                                    {bus_a.sram_ub_n, bus_a.sram_lb_n});
  end

  always @(negedge clk) begin
    bus_a.sram_din = bus_a.sram_oe_n ? 16'h0000 : sram_rd(bus_a.sram_addr);
    bus_b.sram_din = bus_b.sram_oe_n ? 16'h0000 : pat(bus_b.sram_addr);
  end

  typedef struct {
    logic [15:0] rd;
    int          lat, we_cnt, oe_cnt, doe_cnt, other_ok;
    logic        ub, lb, doe_after, busy_after;
  } obs_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [AW-1:0] addr;
    logic [15:0] din;
    logic [1:0]  dsn;
    logic [15:0] exp;
  } vec_t;

  // One access on dut_a: raise cs, watch strobes until ok, drop cs
  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [15:0] din, input logic [1:0] dsn, output obs_t o);
    bit done = 0;
    o = '{16'h0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    if (port) begin
      bus_a.p1_we = we; bus_a.p1_addr = addr; bus_a.p1_din = din; bus_a.p1_dsn = dsn; bus_a.p1_cs = 1;
    end else begin
      bus_a.p0_we = we; bus_a.p0_addr = addr; bus_a.p0_din = din; bus_a.p0_dsn = dsn; bus_a.p0_cs = 1;
    end
    while (!done && o.lat < 40) begin
      @(negedge clk);
      o.lat++;
      if (!bus_a.sram_we_n) begin o.we_cnt++; o.ub = bus_a.sram_ub_n; o.lb = bus_a.sram_lb_n; end
      if (!bus_a.sram_oe_n) o.oe_cnt++;
      if (bus_a.sram_doe) o.doe_cnt++;
      if (port ? bus_a.p0_ok : bus_a.p1_ok) o.other_ok++;
      if (port ? bus_a.p1_ok : bus_a.p0_ok) begin
        done = 1;
        o.rd = port ? bus_a.p1_dout : bus_a.p0_dout;
        // drop the request and scramble the bus; the DUT must not care
        bus_a.p0_cs = 0; bus_a.p1_cs = 0;
        bus_a.p0_addr = '1; bus_a.p1_addr = '1; bus_a.p0_din = 16'hDEAD; bus_a.p1_din = 16'hDEAD;
      end
    end
    bus_a.p0_cs = 0; bus_a.p1_cs = 0;
    @(negedge clk);
    o.doe_after  = bus_a.sram_doe;
    o.busy_after = bus_a.busy;
  endtask

  // Compare one completed access against the reference memory
  task automatic check_access(input string tag, input bit we, input logic [AW-1:0] addr,
                              input logic [15:0] din, input logic [1:0] dsn, input obs_t o);
    chk({tag, "_latency"}, o.lat, WA + 2);
    chk({tag, "_other_ok"}, o.other_ok, 0);
    chk({tag, "_idle_doe_busy"}, {o.doe_after, o.busy_after}, 2'b00);
    if (we) begin
      ref_mem[addr] = merge(ref_rd(addr), din, dsn);
      chk({tag, "_we_cycles"}, o.we_cnt, WA);
      chk({tag, "_doe_cycles"}, o.doe_cnt, WA + 2);
      chk({tag, "_byte_en"}, {o.ub, o.lb}, dsn);
      chk({tag, "_stored"}, sram_rd(addr), ref_rd(addr));
    end else begin
      chk({tag, "_oe_cycles"}, o.oe_cnt, WA + 1);
      chk({tag, "_rdata"}, o.rd, ref_rd(addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    obs_t o;
    int   grants[$];
    int   ok_t[$];
    int   both_cnt, dbl_cnt, p1_cnt, cyc;
    logic prev0, prev1;

    vecs[0] = '{1'b1, 1'b1, 21'h1FFFFF, 16'h5A5A, 2'b00, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 21'h1FFFFF, 16'h0000, 2'b00, 16'h5A5A};
    vecs[2] = '{1'b1, 1'b1, 21'h000040, 16'hFFFF, 2'b00, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 21'h000040, 16'h1234, 2'b10, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 21'h000040, 16'h0000, 2'b00, 16'hFF34};
    vecs[5] = '{1'b1, 1'b1, 21'h000041, 16'hABCD, 2'b11, 16'h0000};
    vecs[6] = '{1'b0, 1'b0, 21'h000041, 16'h0000, 2'b00, 16'hA582};
    vecs[7] = '{1'b0, 1'b0, 21'h000123, 16'h0000, 2'b00, 16'hBEEF};
    vecs[8] = '{1'b0, 1'b1, 21'h000050, 16'hC3C3, 2'b01, 16'h0000};

    sram[21'h123]    = 16'hBEEF;
    ref_mem[21'h123] = 16'hBEEF;

    rst = 1;
    bus_a.p0_cs = 0; bus_a.p0_addr = '0; bus_a.p0_we = 0; bus_a.p0_din = 0; bus_a.p0_dsn = 2'b11;
    bus_a.p1_cs = 0; bus_a.p1_addr = '0; bus_a.p1_we = 0; bus_a.p1_din = 0; bus_a.p1_dsn = 2'b11;
    bus_b.p0_cs = 0; bus_b.p0_addr = '0; bus_b.p0_we = 0; bus_b.p0_din = 0; bus_b.p0_dsn = 2'b11;
    bus_b.p1_cs = 0; bus_b.p1_addr = '0; bus_b.p1_we = 0; bus_b.p1_din = 0; bus_b.p1_dsn = 2'b11;
    repeat (3) @(negedge clk);

    // reset values
    chk("reset_strobes", {bus_a.sram_we_n, bus_a.sram_oe_n, bus_a.sram_ub_n, bus_a.sram_lb_n,
                          bus_a.sram_doe, bus_a.busy, bus_a.p0_ok, bus_a.p1_ok}, 8'b1111_0000);
    chk("reset_addr", bus_a.sram_addr, 0);
    chk("reset_sdout", bus_a.sram_dout, 0);
    chk("reset_douts", {bus_a.p0_dout, bus_a.p1_dout}, 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("idle_no_request", {bus_a.busy, bus_a.sram_we_n, bus_a.sram_oe_n}, 3'b011);

    // directed table
    for (int i = 0; i < 9; i++) begin
      access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].dsn, o);
      check_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].dsn, o);
      if (!vecs[i].we) chk($sformatf("vec%0d_table_data", i), o.rd, vecs[i].exp);
    end
    chk("byte_merge_0x50", sram_rd(21'h50), 16'hC393);

    // randomized transactions vs reference memory
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] pool [4];
      logic [AW-1:0] a;
      bit port, we;
      logic [15:0] d;
      logic [1:0] dsn;
      pool[0] = 21'h10; pool[1] = 21'h11; pool[2] = 21'h1FFFF0; pool[3] = 21'h3;
      a    = pool[$urandom_range(0, 3)];
      port = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      d    = 16'($urandom);
      dsn  = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      access(port, we, a, d, dsn, o);
      check_access($sformatf("rnd%0d", i), we, a, d, dsn, o);
    end

    // contention: both held high, every (SA+1)th grant goes to port 1
    bus_a.p0_we = 0; bus_a.p0_addr = 21'h123; bus_a.p0_cs = 1;
    bus_a.p1_we = 0; bus_a.p1_addr = 21'h10;  bus_a.p1_cs = 1;
    both_cnt = 0; dbl_cnt = 0; prev0 = 0; prev1 = 0; cyc = 0;
    while (grants.size() < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus_a.p0_ok && bus_a.p1_ok) both_cnt++;
      if ((bus_a.p0_ok && prev0) || (bus_a.p1_ok && prev1)) dbl_cnt++;
      if (bus_a.p0_ok) begin
        grants.push_back(0);
        chk("cont_p0_data", bus_a.p0_dout, ref_rd(21'h123));
      end
      if (bus_a.p1_ok) begin
        grants.push_back(1);
        chk("cont_p1_data", bus_a.p1_dout, ref_rd(21'h10));
      end
      prev0 = bus_a.p0_ok; prev1 = bus_a.p1_ok;
    end
    bus_a.p0_cs = 0; bus_a.p1_cs = 0;
    chk("cont_grant_count", grants.size(), 6);
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("cont_grant%0d", i), grants[i], ((i % (SA + 1)) == SA) ? 1 : 0);
    chk("cont_both_ok", both_cnt, 0);
    chk("cont_ok_pulse_width", dbl_cnt, 0);
    repeat (3) @(negedge clk);

    // reset during the ACCESS cycle of a port 1 write
    p1_cnt = 0;
    bus_a.p1_we = 1; bus_a.p1_addr = 21'h20; bus_a.p1_din = 16'h1111; bus_a.p1_dsn = 2'b00; bus_a.p1_cs = 1;
    repeat (2) @(negedge clk);
    chk("rst_pre_we_low", bus_a.sram_we_n, 1'b0);
    rst = 1;
    bus_a.p1_cs = 0;
    bus_a.p0_we = 0; bus_a.p0_addr = 21'h123; bus_a.p0_cs = 1;
    @(negedge clk);
    chk("rst_abort_pins", {bus_a.sram_we_n, bus_a.sram_oe_n, bus_a.sram_doe, bus_a.busy}, 4'b1100);
    if (bus_a.p1_ok) p1_cnt++;
    rst = 0;
    cyc = 0;
    while (!bus_a.p0_ok && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus_a.p1_ok) p1_cnt++;
    end
    chk("rst_p0_latency", cyc, WA + 2);
    chk("rst_p0_data", bus_a.p0_dout, 16'hBEEF);
    bus_a.p0_cs = 0;
    repeat (3) @(negedge clk) if (bus_a.p1_ok) p1_cnt++;
    chk("rst_no_p1_ok", p1_cnt, 0);

    // WAIT=1 instance: back-to-back reads with cs held high
    bus_b.p0_we = 0; bus_b.p0_addr = 21'h77; bus_b.p0_cs = 1;
    cyc = 0; p1_cnt = 0;
    while (ok_t.size() < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus_b.p1_ok) p1_cnt++;
      if (bus_b.p0_ok) begin
        ok_t.push_back(cyc);
        chk("b2b_data", bus_b.p0_dout, 16'h0077 ^ 16'hA5C3);
      end
    end
    bus_b.p0_cs = 0;
    chk("b2b_ok_count", ok_t.size(), 4);
    if (ok_t.size() > 0) chk("b2b_first_latency", ok_t[0], WB + 2);
    for (int i = 1; i < ok_t.size(); i++)
      chk($sformatf("b2b_period%0d", i), ok_t[i] - ok_t[i-1], WB + 3);
    chk("b2b_no_p1_ok", p1_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
